// File: rtl/word_match_pkg.sv
// Shared definitions for the word match scanner.
//   - state_t : scanner FSM encoding (IDLE / SCAN / DONE)
//   - DATA_W  : data word width (fixed to match equality_32)
//   - CNT_W   : default width of the length, index and count fields
package word_match_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : word_match_pkg

// File: rtl/equality_32.sv
// 32-bit equality comparator.
// Ports:
//   a_i  : first operand
//   b_i  : second operand
//   eq_o : 1 when a_i and b_i are bit-for-bit identical
module equality_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        eq_o
);

  assign eq_o = (a_i == b_i);

endmodule : equality_32

// File: rtl/word_match_scanner.sv
// Word match scanner: holds a programmed pattern, scans a stream of a
// programmed length over a valid/ready input and, per accepted word,
// counts matches and records the index of the first match.
//
// Handshake: a word is transferred (a "beat") on a rising edge where
// in_valid & in_ready are both 1. in_ready depends only on the FSM state
// (high exactly in SCAN), never on in_valid, so the producer may hold
// in_valid/in_data for as long as it likes while in_ready is low.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   pat_we, pat_data    : pattern load (honoured in IDLE/DONE only)
//   start, scan_len     : begin a scan of scan_len words (IDLE/DONE only)
//   in_valid, in_data   : input stream
//   in_ready            : stream accepted this cycle (state == SCAN)
//   busy                : state == SCAN
//   done                : state == DONE (level, holds until next start)
//   found               : at least one match in current/last scan
//   match_cnt           : matching word count (saturating)
//   first_idx           : 0-based index of first match, 0 if none
//   state_dbg           : raw FSM state for observation
module word_match_scanner #(
  parameter int DATA_W = word_match_pkg::DATA_W,
  parameter int CNT_W  = word_match_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pat_we,
  input  logic [DATA_W-1:0] pat_data,
  input  logic              start,
  input  logic [CNT_W-1:0]  scan_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_idx,
  output logic [1:0]        state_dbg
);

  word_match_pkg::state_t state_q, state_d;

  logic [DATA_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              found_q, found_d;

  logic eq;
  logic beat;
  logic last_beat;

  // The comparator is 32 bits wide; DATA_W is expected to stay at 32.
  equality_32 u_eq (
    .a_i  (pat_q),
    .b_i  (in_data),
    .eq_o (eq)
  );

  assign beat      = in_valid && (state_q == word_match_pkg::ST_SCAN);
  // len_q is at least 1 whenever SCAN is entered, so len_q-1 cannot wrap.
  assign last_beat = beat && (idx_q == len_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    found_d = found_q;

    case (state_q)
      word_match_pkg::ST_IDLE,
      word_match_pkg::ST_DONE: begin
        // Pattern write lands in the same edge as start, so a combined
        // pat_we+start scans entirely against the new pattern.
        if (pat_we) begin
          pat_d = pat_data;
        end
        if (start) begin
          cnt_d   = '0;
          first_d = '0;
          found_d = 1'b0;
          idx_d   = '0;
          len_d   = scan_len;
          state_d = (scan_len == '0) ? word_match_pkg::ST_DONE
                                     : word_match_pkg::ST_SCAN;
        end
      end

      word_match_pkg::ST_SCAN: begin
        // start and pat_we are deliberately ignored while scanning.
        if (beat) begin
          idx_d = idx_q + CNT_W'(1);
          if (eq) begin
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (!found_q) begin
              first_d = idx_q;
              found_d = 1'b1;
            end
          end
          if (last_beat) begin
            state_d = word_match_pkg::ST_DONE;
          end
        end
      end

      default: begin
        state_d = word_match_pkg::ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= word_match_pkg::ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      found_q <= found_d;
    end
  end

  assign in_ready  = (state_q == word_match_pkg::ST_SCAN);
  assign busy      = (state_q == word_match_pkg::ST_SCAN);
  assign done      = (state_q == word_match_pkg::ST_DONE);
  assign found     = found_q;
  assign match_cnt = cnt_q;
  assign first_idx = first_q;
  assign state_dbg = state_q;

endmodule : word_match_scanner

// File: tb/tb_word_match_scanner.sv
// Self-checking bench for word_match_scanner: table of directed scans,
// hand-written corner sequences (reset mid-scan, pattern write during
// scan) and randomized scans checked against a reference model.
module tb_word_match_scanner;

  logic        clk;
  logic        rst_n;
  logic        pat_we;
  logic [31:0] pat_data;
  logic        start;
  logic [15:0] scan_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        found;
  logic [15:0] match_cnt;
  logic [15:0] first_idx;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] stim_q[$];

  typedef struct {
    string            name;
    logic [31:0]      pat;
    int               mode;   // 0: load before start, 1: load with start, 2: no load
    int               len;
    logic [3:0][31:0] w;
    int               gap;
    logic [15:0]      e_cnt;
    logic [15:0]      e_first;
    bit               e_found;
  } vec_t;

  vec_t vecs[7];

  word_match_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pat_we    (pat_we),
    .pat_data  (pat_data),
    .start     (start),
    .scan_len  (scan_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .match_cnt (match_cnt),
    .first_idx (first_idx),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_found"}, 32'(found), 32'd0);
    check({name, "_cnt"}, 32'(match_cnt), 32'd0);
    check({name, "_first"}, 32'(first_idx), 32'd0);
    check({name, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // Reference: count matches and locate the first one over the stream.
  function automatic void model(input logic [31:0] p, input int len,
                                output logic [15:0] cnt, output logic [15:0] first,
                                output bit fnd);
    cnt = 0; first = 0; fnd = 0;
    for (int i = 0; i < len; i++) begin
      if (stim_q[i] == p) begin
        if (!fnd) first = 16'(i);
        fnd = 1;
        cnt = cnt + 16'd1;
      end
    end
  endfunction

  // Run one scan over stim_q[0..len-1] and check timing and results.
  task automatic run_scan(input string name, input logic [31:0] p, input int mode,
                          input int len, input int gap, input bit rand_gap,
                          input logic [15:0] e_cnt, input logic [15:0] e_first,
                          input bit e_found);
    int g;
    if (mode == 0) begin
      pat_we = 1'b1; pat_data = p;
      step();
      pat_we = 1'b0;
    end
    start = 1'b1;
    scan_len = 16'(len);
    if (mode == 1) begin
      pat_we = 1'b1; pat_data = p;
    end
    step();
    start = 1'b0; pat_we = 1'b0; pat_data = $urandom;
    if (len == 0) begin
      check({name, "_zl_done"}, 32'(done), 32'd1);
      check({name, "_zl_ready"}, 32'(in_ready), 32'd0);
    end else begin
      check({name, "_start_busy"}, 32'(busy), 32'd1);
      check({name, "_start_ready"}, 32'(in_ready), 32'd1);
      check({name, "_start_done"}, 32'(done), 32'd0);
      for (int i = 0; i < len; i++) begin
        g = rand_gap ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
        in_valid = 1'b0;
        repeat (g) begin
          in_data = $urandom;
          step();
          check({name, "_gap_done"}, 32'(done), 32'd0);
        end
        in_valid = 1'b1; in_data = stim_q[i];
        step();
        in_valid = 1'b0;
        if (i < len - 1) check({name, "_mid_done"}, 32'(done), 32'd0);
      end
      check({name, "_end_done"}, 32'(done), 32'd1);
      check({name, "_end_ready"}, 32'(in_ready), 32'd0);
      check({name, "_end_busy"}, 32'(busy), 32'd0);
    end
    check({name, "_cnt"}, 32'(match_cnt), 32'(e_cnt));
    check({name, "_first"}, 32'(first_idx), 32'(e_first));
    check({name, "_found"}, 32'(found), 32'(e_found));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] p;
    logic [15:0] m_cnt, m_first;
    bit          m_fnd;
    int          len, mode;

    vecs[0] = '{"mixed",     32'hFF28FF00, 0, 4,
                {32'hFF28FF00, 32'hFF00FF00, 32'hFF28FF00, 32'h1108F302}, 0, 16'd2, 16'd1, 1'b1};
    vecs[1] = '{"nomatch",   32'hFF00FF00, 0, 3,
                {32'h0, 32'h1108F302, 32'hFF28F1F0, 32'h0}, 0, 16'd0, 16'd0, 1'b0};
    vecs[2] = '{"gaps",      32'hFF28FF00, 0, 4,
                {32'hFF28FF00, 32'hFF00FF00, 32'hFF28FF00, 32'h1108F302}, 2, 16'd2, 16'd1, 1'b1};
    vecs[3] = '{"zerolen",   32'hFF28FF00, 2, 0,
                {32'h0, 32'h0, 32'h0, 32'h0}, 0, 16'd0, 16'd0, 1'b0};
    vecs[4] = '{"patstart",  32'hFF28F1F0, 1, 1,
                {32'h0, 32'h0, 32'h0, 32'hFF28F1F0}, 0, 16'd1, 16'd0, 1'b1};
    vecs[5] = '{"allmatch",  32'h00000001, 0, 4,
                {32'h1, 32'h1, 32'h1, 32'h1}, 1, 16'd4, 16'd0, 1'b1};
    vecs[6] = '{"lastonly",  32'hDEADBEEF, 1, 3,
                {32'h0, 32'hDEADBEEF, 32'h1, 32'h0}, 0, 16'd1, 16'd2, 1'b1};

    // clock/reset block
    rst_n = 1'b0; pat_we = 1'b0; pat_data = '0; start = 1'b0;
    scan_len = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("idle");

    // table-driven directed scans (packed w: index 0 is the low word)
    foreach (vecs[k]) begin
      stim_q.delete();
      for (int j = 0; j < vecs[k].len; j++) stim_q.push_back(vecs[k].w[j]);
      run_scan(vecs[k].name, vecs[k].pat, vecs[k].mode, vecs[k].len, vecs[k].gap, 1'b0,
               vecs[k].e_cnt, vecs[k].e_first, vecs[k].e_found);
      if (k == 3) begin
        step();
        check("zerolen_hold_done", 32'(done), 32'd1);
        check("zerolen_hold_ready", 32'(in_ready), 32'd0);
      end
    end

    // pattern write during SCAN is ignored
    pat_we = 1'b1; pat_data = 32'hFF28FF00; step(); pat_we = 1'b0;
    start = 1'b1; scan_len = 16'd3; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678; step();
    in_valid = 1'b0; pat_we = 1'b1; pat_data = 32'h0; step(); pat_we = 1'b0;
    in_valid = 1'b1; in_data = 32'hFF28FF00; step();
    in_data = 32'h0; step(); in_valid = 1'b0;
    check("patscan_done", 32'(done), 32'd1);
    check("patscan_cnt", 32'(match_cnt), 32'd1);
    check("patscan_first", 32'(first_idx), 32'd1);
    check("patscan_found", 32'(found), 32'd1);
    // start ignored in SCAN: scan of 2, start pulsed mid-scan with len 0
    start = 1'b1; scan_len = 16'd2; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'hFF28FF00; step();
    in_valid = 1'b0; start = 1'b1; scan_len = 16'd0; step(); start = 1'b0;
    check("startscan_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 32'h5; step(); in_valid = 1'b0;
    check("startscan_done", 32'(done), 32'd1);
    check("startscan_cnt", 32'(match_cnt), 32'd1);

    // reset during SCAN on word 2 of 4
    start = 1'b1; scan_len = 16'd4; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'h1108F302; step();
    in_data = 32'hFF28FF00; step(); in_valid = 1'b0;
    check("prerst_found", 32'(found), 32'd1);
    rst_n = 1'b0; step();
    check_all_zero("rst1");
    step();
    check_all_zero("rst2");
    rst_n = 1'b1;
    // pattern was reset to zero: a zero word must match at index 0
    stim_q.delete(); stim_q.push_back(32'h0);
    run_scan("postrst_pat0", 32'h0, 2, 1, 0, 1'b0, 16'd1, 16'd0, 1'b1);
    stim_q.delete();
    stim_q.push_back(32'h1108F302); stim_q.push_back(32'hFF28FF00);
    stim_q.push_back(32'hFF00FF00); stim_q.push_back(32'hFF28FF00);
    run_scan("postrst_mixed", 32'hFF28FF00, 1, 4, 0, 1'b0, 16'd2, 16'd1, 1'b1);

    // randomized scans against the reference model
    for (int r = 0; r < 40; r++) begin
      p = $urandom;
      len = int'($urandom_range(0, 9));
      mode = int'($urandom_range(0, 1));
      stim_q.delete();
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 2) == 0) stim_q.push_back(p);
        else stim_q.push_back($urandom);
      end
      model(p, len, m_cnt, m_first, m_fnd);
      run_scan($sformatf("rand%0d", r), p, mode, len, 0, 1'b1, m_cnt, m_first, m_fnd);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_word_match_scanner
